// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: widths, opcodes, the T-state
// encoding, the control-word bit layout and the ALU operation codes.
package cu_pkg;

    localparam int unsigned CTRL_W = 28;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned STEP_W = 4;

    // Instruction opcodes (IR[31:27])
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU operation select
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;

    // T-state encoding doubles as the debug step value (T0W reports as 0)
    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_RST  = 4'd8,
        ST_T0W  = 4'd9,
        ST_HALT = 4'd15
    } state_e;

    // Control word layout: pc_out is bit 27, spare is bit 0
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic read;
        logic ram_in;
        logic y_in;
        logic zlow_in;
        logic zlow_out;
        logic zhigh_in;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic hi_out;
        logic lo_out;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic con_in;
        logic r15_in;
        logic spare;
    } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// control_unit: Moore T-state sequencer for a simple RISC datapath.
//   Clock   - rising-edge system clock
//   Clear   - asynchronous active-low reset
//   step_go - (only with CU_SINGLE_STEP_EN) release the next instruction
//   opcode  - IR[31:27]; must be stable by the end of T2
//   CON_FF  - branch condition flag
//   ctrl    - registered control word (layout: cu_pkg::ctrl_t)
//   alu_op  - registered ALU select
//   Run     - 1 while sequencing, 0 in HALT
//   step    - registered T-state number (RST=8, HALT=15)
// Build option CU_SINGLE_STEP_EN: the FSM idles in T0 with ctrl=0 until
// step_go is sampled high, then issues the T0 fetch word the next cycle.
module control_unit
    import cu_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
`ifdef CU_SINGLE_STEP_EN
    input  logic              step_go,
`endif
    input  logic [OP_W-1:0]   opcode,
    input  logic              CON_FF,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ALU_W-1:0]  alu_op,
    output logic              Run,
    output logic [STEP_W-1:0] step
);

`ifdef CU_SINGLE_STEP_EN
    localparam state_e FETCH_ST = ST_T0W;
`else
    localparam state_e FETCH_ST = ST_T0;
`endif

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [ALU_W-1:0]   alu_q, alu_d;
    logic               run_q, run_d;
    logic [STEP_W-1:0]  step_q, step_d;

    // State, latched opcode and output registers
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_RST;
            op_q    <= '0;
            ctrl_q  <= '0;
            alu_q   <= ALU_ADD;
            run_q   <= 1'b1;
            step_q  <= STEP_W'(ST_RST);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            run_q   <= run_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic; opcode is captured on the T2->T3 edge
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_RST:  state_d = FETCH_ST;
            ST_T0W: begin
`ifdef CU_SINGLE_STEP_EN
                if (step_go) state_d = ST_T0;
`else
                state_d = ST_T0;
`endif
            end
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                state_d = ST_T3;
                op_d    = opcode;
            end
            ST_T3: begin
                case (op_q)
                    OP_JAL, OP_ADD, OP_SUB,
                    OP_LD, OP_ST, OP_BR:    state_d = ST_T4;
                    OP_HALT:                state_d = ST_HALT;
                    default:                state_d = FETCH_ST;
                endcase
            end
            ST_T4:   state_d = (op_q == OP_JAL) ? FETCH_ST : ST_T5;
            ST_T5:   state_d = (op_q == OP_ADD || op_q == OP_SUB) ? FETCH_ST : ST_T6;
            ST_T6:   state_d = (op_q == OP_BR) ? FETCH_ST : ST_T7;
            ST_T7:   state_d = FETCH_ST;
            ST_HALT: state_d = ST_HALT;
            default: state_d = FETCH_ST;
        endcase
    end

    // Output decode of the state being entered, so registered outputs line
    // up with the state. The br T6 decision uses CON_FF at the T5->T6 edge;
    // CON_FF is already settled since CONin fired in T3.
    always_comb begin
        ctrl_d = '0;
        alu_d  = ALU_ADD;
        run_d  = (state_d != ST_HALT);
        step_d = (state_d == ST_T0W) ? STEP_W'(0) : STEP_W'(state_d);
        case (state_d)
            ST_T0: begin
                ctrl_d.pc_out  = 1'b1;
                ctrl_d.mar_in  = 1'b1;
                ctrl_d.inc_pc  = 1'b1;
                ctrl_d.zlow_in = 1'b1;
            end
            ST_T1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (op_d)
                    OP_JR:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
                    OP_JAL: begin ctrl_d.pc_out = 1'b1; ctrl_d.r15_in = 1'b1; end
                    OP_ADD, OP_SUB: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
                    OP_LD, OP_ST:   begin ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1; end
                    OP_BR:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.con_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_d)
                    OP_JAL: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
                    OP_ADD, OP_SUB: begin
                        ctrl_d.grc     = 1'b1;
                        ctrl_d.r_out   = 1'b1;
                        ctrl_d.zlow_in = 1'b1;
                        alu_d          = (op_d == OP_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    OP_LD, OP_ST: begin ctrl_d.c_out = 1'b1; ctrl_d.zlow_in = 1'b1; end
                    OP_BR:  begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_d)
                    OP_ADD, OP_SUB: begin ctrl_d.zlow_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                    OP_LD, OP_ST:   begin ctrl_d.zlow_out = 1'b1; ctrl_d.mar_in = 1'b1; end
                    OP_BR:  begin ctrl_d.c_out = 1'b1; ctrl_d.zlow_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op_d)
                    OP_LD: begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
                    OP_ST: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
                    OP_BR: begin ctrl_d.zlow_out = 1'b1; ctrl_d.pc_in = CON_FF; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op_d)
                    OP_LD: begin ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                    OP_ST: ctrl_d.ram_in = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign ctrl   = ctrl_q;
    assign alu_op = alu_q;
    assign Run    = run_q;
    assign step   = step_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus side builds each
// instruction's expected per-cycle output sequence from the instruction
// tables and queues it; an independent monitor compares every cycle.
module tb_control_unit;
    import cu_pkg::*;

`ifdef CU_SINGLE_STEP_EN
    localparam int WAITS = 1;
    logic step_go;
`else
    localparam int WAITS = 0;
`endif

    logic              Clock = 1'b0;
    logic              Clear = 1'b1;
    logic [OP_W-1:0]   opcode = '0;
    logic              CON_FF = 1'b0;
    logic [CTRL_W-1:0] ctrl;
    logic [ALU_W-1:0]  alu_op;
    logic              Run;
    logic [STEP_W-1:0] step;

    control_unit dut (
        .Clock  (Clock),
        .Clear  (Clear),
`ifdef CU_SINGLE_STEP_EN
        .step_go(step_go),
`endif
        .opcode (opcode),
        .CON_FF (CON_FF),
        .ctrl   (ctrl),
        .alu_op (alu_op),
        .Run    (Run),
        .step   (step)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [ALU_W-1:0]  a;
        logic [STEP_W-1:0] s;
        logic              r;
    } exp_t;

    exp_t              exp_q[$];
    ctrl_t             seq_c[$];
    logic [ALU_W-1:0]  seq_a[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    bit                mon_on = 1'b0;
    int                len;

    function automatic void addw(input ctrl_t v, input logic [ALU_W-1:0] a);
        seq_c.push_back(v);
        seq_a.push_back(a);
    endfunction

    function automatic void push_exp(input logic [CTRL_W-1:0] c, input logic [ALU_W-1:0] a,
                                     input logic [STEP_W-1:0] s, input logic r);
        exp_t e;
        e.c = c; e.a = a; e.s = s; e.r = r;
        exp_q.push_back(e);
    endfunction

    // Expected outputs for one instruction: nwait idle T0 cycles, fetch,
    // then the execute steps; keep>=0 truncates to the first keep T-states.
    task automatic push_instr(input logic [OP_W-1:0] op, input logic con,
                              input int nwait, input int keep, output int n);
        ctrl_t f;
        seq_c.delete();
        seq_a.delete();
        n = 0;
        for (int i = 0; i < nwait; i++) begin
            push_exp('0, ALU_ADD, 4'd0, 1'b1);
            n++;
        end
        f = '0; f.pc_out = 1'b1; f.mar_in = 1'b1; f.inc_pc = 1'b1; f.zlow_in = 1'b1; addw(f, ALU_ADD);
        f = '0; f.zlow_out = 1'b1; f.pc_in = 1'b1; f.read = 1'b1; f.mdr_in = 1'b1; addw(f, ALU_ADD);
        f = '0; f.mdr_out = 1'b1; f.ir_in = 1'b1; addw(f, ALU_ADD);
        case (op)
            OP_JR: begin
                f = '0; f.gra = 1'b1; f.r_out = 1'b1; f.pc_in = 1'b1; addw(f, ALU_ADD);
            end
            OP_JAL: begin
                f = '0; f.pc_out = 1'b1; f.r15_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.gra = 1'b1; f.r_out = 1'b1; f.pc_in = 1'b1; addw(f, ALU_ADD);
            end
            OP_ADD, OP_SUB: begin
                f = '0; f.grb = 1'b1; f.r_out = 1'b1; f.y_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.grc = 1'b1; f.r_out = 1'b1; f.zlow_in = 1'b1;
                addw(f, (op == OP_SUB) ? 4'b0001 : 4'b0000);
                f = '0; f.zlow_out = 1'b1; f.gra = 1'b1; f.r_in = 1'b1; addw(f, ALU_ADD);
            end
            OP_LD, OP_ST: begin
                f = '0; f.grb = 1'b1; f.ba_out = 1'b1; f.y_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.c_out = 1'b1; f.zlow_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.zlow_out = 1'b1; f.mar_in = 1'b1; addw(f, ALU_ADD);
                if (op == OP_LD) begin
                    f = '0; f.read = 1'b1; f.mdr_in = 1'b1; addw(f, ALU_ADD);
                    f = '0; f.mdr_out = 1'b1; f.gra = 1'b1; f.r_in = 1'b1; addw(f, ALU_ADD);
                end else begin
                    f = '0; f.gra = 1'b1; f.r_out = 1'b1; f.mdr_in = 1'b1; addw(f, ALU_ADD);
                    f = '0; f.ram_in = 1'b1; addw(f, ALU_ADD);
                end
            end
            OP_BR: begin
                f = '0; f.gra = 1'b1; f.r_out = 1'b1; f.con_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.pc_out = 1'b1; f.y_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.c_out = 1'b1; f.zlow_in = 1'b1; addw(f, ALU_ADD);
                f = '0; f.zlow_out = 1'b1; f.pc_in = con; addw(f, ALU_ADD);
            end
            default: addw('0, ALU_ADD);
        endcase
        if (keep >= 0) begin
            while (seq_c.size() > keep) begin
                void'(seq_c.pop_back());
                void'(seq_a.pop_back());
            end
        end
        for (int i = 0; i < seq_c.size(); i++) begin
            push_exp(seq_c[i], seq_a[i], STEP_W'(i), 1'b1);
            n++;
        end
        if (op == OP_HALT && keep < 0) begin
            for (int i = 0; i < 20; i++) begin
                push_exp('0, ALU_ADD, 4'd15, 1'b0);
                n++;
            end
        end
    endtask

    task automatic run_instr(input logic [OP_W-1:0] op, input logic con);
        opcode = op;
        CON_FF = con;
        push_instr(op, con, WAITS, -1, len);
        repeat (len) @(negedge Clock);
    endtask

    task automatic push_reset(input int cycles);
        for (int i = 0; i < cycles; i++) push_exp('0, ALU_ADD, 4'd8, 1'b1);
    endtask

    // Monitor: one comparison per clock, sampled just after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #2;
            if (mon_on) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL underflow t=%0t: DUT ctrl=%h step=%0d with no expected entry",
                             $time, ctrl, step);
                end else begin
                    e = exp_q.pop_front();
                    if (ctrl !== e.c || alu_op !== e.a || step !== e.s || Run !== e.r) begin
                        n_bad++;
                        $display("FAIL cycle t=%0t op=%b: got ctrl=%h alu=%h step=%0d run=%b, need ctrl=%h alu=%h step=%0d run=%b",
                                 $time, opcode, ctrl, alu_op, step, Run, e.c, e.a, e.s, e.r);
                    end
                end
            end
        end
    end

    logic [OP_W-1:0] defs[8];
    logic [OP_W-1:0] rop;

    initial begin
        defs = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_BR, OP_JR, OP_JAL, OP_NOP};
`ifdef CU_SINGLE_STEP_EN
        step_go = 1'b1;
`endif
        #1 Clear = 1'b0;
        @(negedge Clock);
        push_reset(2);
        mon_on = 1'b1;
        repeat (2) @(negedge Clock);
        Clear = 1'b1;

`ifdef CU_SINGLE_STEP_EN
        // Held in T0 with ctrl=0 for 10 cycles, then fetch follows step_go
        step_go = 1'b0;
        opcode = OP_JR;
        push_instr(OP_JR, 1'b0, 10, -1, len);
        repeat (10) @(negedge Clock);
        step_go = 1'b1;
        repeat (len - 10) @(negedge Clock);
`endif

        run_instr(OP_JR, 1'b0);
        run_instr(OP_BR, 1'b0);
        run_instr(OP_BR, 1'b1);
        run_instr(OP_LD, 1'b0);
        run_instr(OP_ST, 1'b1);
        run_instr(OP_JAL, 1'b0);
        run_instr(OP_ADD, 1'b1);
        run_instr(OP_SUB, 1'b0);
        run_instr(OP_NOP, 1'b0);
        run_instr(5'b01111, 1'b1);
        run_instr(5'b11111, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) rop = OP_W'($urandom_range(0, 31));
            else                           rop = defs[$urandom_range(0, 7)];
            if (rop == OP_HALT) rop = OP_NOP;
            run_instr(rop, 1'($urandom_range(0, 1)));
        end

        // Clear arriving just inside T5 of add: outputs drop at once, no Rin
        opcode = OP_ADD;
        push_instr(OP_ADD, 1'b0, WAITS, 5, len);
        push_reset(2);
        repeat (len) @(negedge Clock);
        @(posedge Clock);
        #1 Clear = 1'b0;
        #1;
        n_cmp++;
        if (ctrl !== '0 || step !== 4'd8 || Run !== 1'b1) begin
            n_bad++;
            $display("FAIL async_clear: got ctrl=%h step=%0d run=%b, need ctrl=0 step=8 run=1",
                     ctrl, step, Run);
        end
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        run_instr(OP_ADD, 1'b0);

        // Halt holds for 20 cycles, then a Clear pulse restarts fetch
        run_instr(OP_HALT, 1'b0);
        Clear = 1'b0;
        push_reset(2);
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        run_instr(OP_JR, 1'b1);
        run_instr(OP_LD, 1'b0);

        mon_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected entries unconsumed, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
